// File: rtl/lsu_store_buffer.sv
// MEM-stage load/store unit: byte-lane generation, load extension, a FIFO store
// buffer drained to the dcache in the background, and store-to-load forwarding.
module lsu_store_buffer #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int SB_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rw,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [4:0]          req_rd,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic [4:0]          resp_rd,
  output logic                misaligned,
  output logic                stall,
  output logic                dcache_dataRequest,
  output logic                dcache_rw,
  output logic [ADDR_W-1:0]   dcache_address,
  output logic [DATA_W-1:0]   dcache_writeData,
  output logic [DATA_W/8-1:0] dcache_byte_en,
  input  logic [DATA_W-1:0]   dcache_readData,
  input  logic                dcache_data_ready
);
  localparam int BE_W = DATA_W / 8;
  localparam int LW   = $clog2(BE_W);
  localparam int WA_W = ADDR_W - LW;
  localparam int PW   = $clog2(SB_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  state_t state, next;

  logic [WA_W-1:0]   sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] sb_data [SB_DEPTH];
  logic [BE_W-1:0]   sb_be   [SB_DEPTH];
  logic [PW-1:0]     head, tail;
  logic [PW:0]       cnt;

  logic              lp_valid, lp_signed;
  logic [WA_W-1:0]   lp_wa;
  logic [LW-1:0]     lp_lane;
  logic [1:0]        lp_size;
  logic [4:0]        lp_rd;

  function automatic logic [BE_W-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return BE_W'(1);
      2'd1:    return BE_W'(3);
      2'd2:    return BE_W'(15);
      default: return '1;
    endcase
  endfunction

  // Keep the low (1<<size) bytes; upper bits get the access's sign bit or zero.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [1:0] size, input logic sgn);
    logic [BE_W-1:0]   m;
    logic [DATA_W-1:0] bm;
    logic              sb;
    m = size_mask(size);
    for (int i = 0; i < BE_W; i++) bm[8*i +: 8] = {8{m[i]}};
    case (size)
      2'd0:    sb = d[7];
      2'd1:    sb = d[15];
      2'd2:    sb = d[31];
      default: sb = d[DATA_W-1];
    endcase
    return (d & bm) | ({DATA_W{sgn & sb}} & ~bm);
  endfunction

  logic [LW-1:0]     lane;
  logic [WA_W-1:0]   req_wa;
  logic [BE_W-1:0]   req_be;
  logic [2:0]        amask;
  logic              misal;

  assign lane   = req_addr[LW-1:0];
  assign req_wa = req_addr[ADDR_W-1:LW];
  assign req_be = size_mask(req_size) << lane;

  always_comb begin
    case (req_size)
      2'd0:    amask = 3'd0;
      2'd1:    amask = 3'd1;
      2'd2:    amask = 3'd3;
      default: amask = 3'd7;
    endcase
  end
  assign misal = (|(req_addr[2:0] & amask)) || (req_size == 2'd3 && DATA_W == 32);

  // Scan oldest to youngest so the last match seen is the youngest.
  logic              hit_any, fwd_full;
  logic [DATA_W-1:0] fwd_data;
  logic [PW-1:0]     idx;
  always_comb begin
    hit_any  = 1'b0;
    fwd_full = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head + PW'(i);
      if (i < int'(cnt) && sb_addr[idx] == req_wa) begin
        hit_any  = 1'b1;
        fwd_full = ((sb_be[idx] & req_be) == req_be);
        fwd_data = sb_data[idx];
      end
    end
  end

  logic retire, sb_full, acc, acc_st, acc_ld, acc_fwd;
  assign retire  = (state == DRAIN) && dcache_data_ready;
  assign sb_full = (cnt == (PW+1)'(SB_DEPTH));

  always_comb begin
    req_ready = 1'b0;
    if (req_valid && state != LOAD) begin
      if (misal)       req_ready = 1'b1;
      else if (req_rw) req_ready = !sb_full || retire;
      else             req_ready = !lp_valid && (!hit_any || fwd_full);
    end
  end

  assign stall   = req_valid & ~req_ready;
  assign acc     = req_valid & req_ready;
  assign acc_st  = acc & ~misal & req_rw;
  assign acc_ld  = acc & ~misal & ~req_rw & ~hit_any;
  assign acc_fwd = acc & ~misal & ~req_rw & hit_any;

  always_comb begin
    next               = state;
    dcache_dataRequest = 1'b0;
    dcache_rw          = 1'b0;
    dcache_address     = '0;
    dcache_writeData   = '0;
    dcache_byte_en     = '0;
    case (state)
      IDLE: begin
        if (lp_valid || acc_ld) next = LOAD;
        else if (cnt != '0)     next = DRAIN;
      end
      LOAD: begin
        dcache_dataRequest = 1'b1;
        dcache_address     = {lp_wa, {LW{1'b0}}};
        dcache_byte_en     = '1;
        if (dcache_data_ready) next = IDLE;
      end
      DRAIN: begin
        dcache_dataRequest = 1'b1;
        dcache_rw          = 1'b1;
        dcache_address     = {sb_addr[head], {LW{1'b0}}};
        dcache_writeData   = sb_data[head];
        dcache_byte_en     = sb_be[head];
        // A pending load gets the port as soon as the in-flight store completes.
        if (dcache_data_ready)
          next = (cnt > (PW+1)'(1) && !lp_valid && !acc_ld) ? DRAIN : IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (acc_st) begin
      sb_addr[tail] <= req_wa;
      sb_data[tail] <= req_wdata << {lane, 3'b000};
      sb_be[tail]   <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
      lp_valid   <= 1'b0;
      lp_signed  <= 1'b0;
      lp_wa      <= '0;
      lp_lane    <= '0;
      lp_size    <= '0;
      lp_rd      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= '0;
      misaligned <= 1'b0;
    end else begin
      state      <= next;
      resp_valid <= 1'b0;
      misaligned <= acc & misal;
      if (acc_st) tail <= tail + PW'(1);
      if (retire) head <= head + PW'(1);
      case ({acc_st, retire})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (acc_ld) begin
        lp_valid  <= 1'b1;
        lp_signed <= req_signed;
        lp_wa     <= req_wa;
        lp_lane   <= lane;
        lp_size   <= req_size;
        lp_rd     <= req_rd;
      end
      if (acc_fwd) begin
        resp_valid <= 1'b1;
        resp_data  <= extend(fwd_data >> {lane, 3'b000}, req_size, req_signed);
        resp_rd    <= req_rd;
      end
      if (state == LOAD && dcache_data_ready) begin
        lp_valid   <= 1'b0;
        resp_valid <= 1'b1;
        resp_data  <= extend(dcache_readData >> {lp_lane, 3'b000}, lp_size, lp_signed);
        resp_rd    <= lp_rd;
      end
    end
  end
endmodule
